// File: rtl/bsm_pkg.sv
// Shared types and helpers for the banked slow line memory.
// Holds the FSM/op encodings and the channel-index width function.
package bsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_COOL = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // A single channel still needs one index bit to keep vectors legal.
  function automatic int ch_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/banked_slow_memory_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer,
// wrapping to the lowest channels below the pointer.
module rr_arbiter
  import bsm_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  input  logic              i_en,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_idx
);

  logic w_hit;

  // Two passes: channels at/above the pointer first, then the wrapped ones.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_hit = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (i_en && !w_hit && i_req[j] && (CH_W'(j) >= i_ptr)) begin
        o_gnt[j] = 1'b1;
        o_idx    = CH_W'(j);
        w_hit    = 1'b1;
      end else begin
        w_hit = w_hit;
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (i_en && !w_hit && i_req[j] && (CH_W'(j) < i_ptr)) begin
        o_gnt[j] = 1'b1;
        o_idx    = CH_W'(j);
        w_hit    = 1'b1;
      end else begin
        w_hit = w_hit;
      end
    end
  end

endmodule

// File: rtl/banked_slow_memory.sv
// Multi-channel slow line memory: one shared line array serialised between
// NUM_CH refill channels with round-robin arbitration and fixed latencies.
module banked_slow_memory
  import bsm_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 28,
  parameter int LINE_W     = 128,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 10,
  parameter int WR_LAT     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        mem_read,
  input  logic [NUM_CH-1:0]        mem_write,
  input  logic [NUM_CH*ADDR_W-1:0] mem_addr,
  input  logic [NUM_CH*LINE_W-1:0] mem_wdata,
  output logic [NUM_CH*LINE_W-1:0] mem_rdata,
  output logic [NUM_CH-1:0]        mem_ready,
  output logic [NUM_CH-1:0]        grant,
  output logic                     busy,
  output logic                     proto_err
);

  localparam int          CH_W    = ch_width(NUM_CH);
  localparam logic [15:0] RD_LOAD = 16'(RD_LAT - 1);
  localparam logic [15:0] WR_LOAD = 16'(WR_LAT - 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_e                  r_state;
  state_e                  w_next_state;
  op_e                     r_op;
  logic [CH_W-1:0]         r_ptr;
  logic [CH_W-1:0]         r_ch;
  logic [DEPTH_LOG2-1:0]   r_addr;
  logic [LINE_W-1:0]       r_wdata;
  logic [15:0]             r_cnt;
  logic [NUM_CH-1:0]       r_grant;
  logic                    r_busy;
  logic [NUM_CH-1:0]       r_ready;
  logic [NUM_CH*LINE_W-1:0] r_rdata;
  logic                    r_err;
  logic [LINE_W-1:0]       r_mem [0:(1<<DEPTH_LOG2)-1];

  logic [NUM_CH-1:0]       w_req;
  logic [NUM_CH-1:0]       w_gnt;
  logic [CH_W-1:0]         w_idx;
  logic                    w_arb_en;
  logic                    w_is_wr;
  logic                    w_is_both;
  logic                    w_unused_addr;
  logic [DEPTH_LOG2-1:0]   w_addr_a  [NUM_CH];
  logic [LINE_W-1:0]       w_wdata_a [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_addr_a[g]  = mem_addr[g*ADDR_W +: DEPTH_LOG2];
    assign w_wdata_a[g] = mem_wdata[g*LINE_W +: LINE_W];
  end

  // Upper address bits alias onto the array and are deliberately dropped.
  assign w_unused_addr = ^mem_addr;

  assign w_req     = mem_read | mem_write;
  assign w_arb_en  = (r_state == ST_IDLE);
  assign w_is_wr   = mem_write[w_idx];
  assign w_is_both = mem_read[w_idx] & mem_write[w_idx];

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: w_next_state = (|w_gnt) ? ST_WAIT : ST_IDLE;
      ST_WAIT: w_next_state = (r_cnt == 16'd0) ? ST_DONE : ST_WAIT;
      ST_DONE: w_next_state = ST_COOL;
      ST_COOL: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= OP_RD;
      r_ptr     <= '0;
      r_ch      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= 16'd0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_ready   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_ch    <= w_idx;
            r_op    <= w_is_wr ? OP_WR : OP_RD;
            r_addr  <= w_addr_a[w_idx];
            r_wdata <= w_wdata_a[w_idx];
            r_cnt   <= w_is_wr ? WR_LOAD : RD_LOAD;
            r_grant <= w_gnt;
            r_busy  <= 1'b1;
            if (w_is_both) r_err <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 16'd0) begin
            // Ready and read data are registered so both appear in DONE.
            r_ready <= r_grant;
            for (int i = 0; i < NUM_CH; i++) begin
              if (r_grant[i] && (r_op == OP_RD)) r_rdata[i*LINE_W +: LINE_W] <= r_mem[r_addr];
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_DONE: begin
          r_ready <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= (r_ch == LAST_CH) ? '0 : r_ch + CH_W'(1);
        end
        ST_COOL: r_ready <= '0;
        default: r_ready <= '0;
      endcase
    end
  end

  // Commit happens on the edge leaving DONE; a reset on that edge suppresses it.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == ST_DONE) && (r_op == OP_WR)) r_mem[r_addr] <= r_wdata;
  end

  assign mem_rdata = r_rdata;
  assign mem_ready = r_ready;
  assign grant     = r_grant;
  assign busy      = r_busy;
  assign proto_err = r_err;

endmodule

// File: tb/tb_banked_slow_memory.sv
// Scoreboard bench for banked_slow_memory: expectations queued at issue time,
// checked every cycle (busy/grant/ready/rdata/proto_err) against the queue head.
module tb_banked_slow_memory;

  localparam int RD_LAT = 10;
  localparam int WR_LAT = 7;

  typedef struct {
    int           ch;
    bit           rd;
    logic [127:0] data;
    int           start;
    int           due;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [1:0]   mem_read;
  logic [1:0]   mem_write;
  logic [55:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic [1:0]   mem_ready;
  logic [1:0]   grant;
  logic         busy;
  logic         proto_err;

  int           cyc = 0;
  int           next_free = 0;
  int           n_total = 0;
  int           n_bad = 0;
  bit           chk_en = 1'b0;
  logic         exp_err;
  logic [255:0] exp_rdata;
  logic [127:0] model [0:1023];
  exp_t         sb [$];

  banked_slow_memory #(
    .NUM_CH (2), .ADDR_W (28), .LINE_W (128), .DEPTH_LOG2 (10),
    .RD_LAT (RD_LAT), .WR_LAT (WR_LAT)
  ) dut (
    .clk (clk), .rst_n (rst_n), .mem_read (mem_read), .mem_write (mem_write),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_rdata (mem_rdata),
    .mem_ready (mem_ready), .grant (grant), .busy (busy), .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // Per-cycle monitor, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    logic       eb;
    logic [1:0] eg;
    logic [1:0] er;
    exp_t       e;
    #1;
    if (chk_en) begin
      eb = 1'b0; eg = 2'b00; er = 2'b00;
      if (sb.size() > 0 && cyc >= sb[0].start && cyc <= sb[0].due) begin
        eb = 1'b1;
        eg = 2'(1 << sb[0].ch);
      end
      chk("busy", 256'(busy), 256'(eb));
      chk("grant", 256'(grant), 256'(eg));
      if (sb.size() > 0 && cyc == sb[0].due) begin
        e  = sb.pop_front();
        er = 2'(1 << e.ch);
        if (e.rd) exp_rdata[e.ch*128 +: 128] = e.data;
      end
      chk("ready", 256'(mem_ready), 256'(er));
      chk("rdata", mem_rdata, exp_rdata);
      chk("proto_err", 256'(proto_err), 256'(exp_err));
    end
  end

  task automatic wait_free();
    while (cyc < next_free - 1) @(negedge clk);
  endtask

  task automatic scramble();
    mem_read  = 2'b00;
    mem_write = 2'b00;
    mem_addr  = 56'({$urandom(), $urandom()});
    mem_wdata = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // One-cycle request; inputs are scrambled afterwards to prove they were latched.
  task automatic issue(input int ch, input bit rd, input bit wr,
                       input logic [27:0] addr, input logic [127:0] data, input bit commit);
    int   t;
    int   lat;
    exp_t e;
    wait_free();
    mem_read[ch]              = rd;
    mem_write[ch]             = wr;
    mem_addr[ch*28 +: 28]     = addr;
    mem_wdata[ch*128 +: 128]  = data;
    t       = cyc + 1;
    lat     = wr ? WR_LAT : RD_LAT;
    e.ch    = ch;
    e.rd    = !wr;
    e.data  = wr ? data : model[addr[9:0]];
    e.start = t;
    e.due   = t + lat;
    sb.push_back(e);
    if (wr && commit) model[addr[9:0]] = data;
    if (rd && wr) exp_err = 1'b1;
    next_free = t + lat + 3;
    @(negedge clk);
    scramble();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    exp_rdata = '0;
    exp_err   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_free = cyc + 1;
  endtask

  initial begin
    int   t;
    exp_t e;
    rst_n = 1'b0; mem_read = 2'b00; mem_write = 2'b00; mem_addr = '0; mem_wdata = '0;
    exp_err = 1'b0; exp_rdata = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    next_free = cyc + 1;

    // Preload, single read, write-then-read across channels.
    issue(0, 1'b0, 1'b1, 28'd5, {4{32'hA5A5A5A5}}, 1'b1);
    issue(0, 1'b1, 1'b0, 28'd5, 128'd0, 1'b1);
    issue(1, 1'b0, 1'b1, 28'd7, 128'h1234, 1'b1);
    issue(0, 1'b1, 1'b0, 28'd7, 128'd0, 1'b1);
    issue(1, 1'b1, 1'b0, 28'd5, 128'd0, 1'b1);

    // Aliasing: upper address bits ignored.
    issue(1, 1'b0, 1'b1, 28'h0000405, 128'hDEAD_BEEF_0000_0000_CAFE_F00D_1111_2222, 1'b1);
    issue(0, 1'b1, 1'b0, 28'd5, 128'd0, 1'b1);

    // Read+write together: treated as a write, error sticks.
    issue(0, 1'b1, 1'b1, 28'd9, 128'h0BAD_0BAD_0BAD_0BAD, 1'b1);
    issue(1, 1'b1, 1'b0, 28'd9, 128'd0, 1'b1);
    issue(1, 1'b1, 1'b0, 28'd7, 128'd0, 1'b1);
    wait_free();
    do_reset();

    // Contention from reset: both held, service must alternate 0,1,0,1.
    wait_free();
    mem_read = 2'b11;
    mem_addr[0 +: 28]  = 28'd5;
    mem_addr[28 +: 28] = 28'd7;
    t = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      e.ch    = k % 2;
      e.rd    = 1'b1;
      e.data  = (k % 2 == 0) ? model[5] : model[7];
      e.start = t + k * (RD_LAT + 3);
      e.due   = e.start + RD_LAT;
      sb.push_back(e);
    end
    while (cyc < t + 3 * (RD_LAT + 3)) @(negedge clk);
    mem_read = 2'b00;
    next_free = t + 4 * (RD_LAT + 3);

    // Reset during WAIT of a write: nothing committed, no ready.
    issue(0, 1'b0, 1'b1, 28'd3, 128'h3333_AAAA, 1'b1);
    issue(1, 1'b0, 1'b1, 28'd3, 128'h4444_BBBB, 1'b0);
    repeat (2) @(negedge clk);
    do_reset();
    issue(0, 1'b1, 1'b0, 28'd3, 128'd0, 1'b1);

    wait_free();
    repeat (3) @(negedge clk);
    chk("sb_empty", 256'(sb.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/banked_slow_memory.md
Name: banked_slow_memory

Overview:
- Parametrised multi-channel successor to the single-port slow line memory used for the I and D sides of CHIP.
- Serves NUM_CH independent cache-refill channels from one shared line array.
- Round-robin arbitration; read and write latencies set independently; single-cycle ready handshake per channel.
- Used by the L2Cache and MultDiv benches where I-cache and D-cache share one backing store.

Parameters:
- NUM_CH, 2: number of requester channels (1..8).
- ADDR_W, 28: line address width (byte address bits [31:4]).
- LINE_W, 128: line data width in bits.
- DEPTH_LOG2, 10: log2 of the number of lines stored; the array is indexed by addr[DEPTH_LOG2-1:0].
- RD_LAT, 10: cycles from grant to read ready (at least 1).
- WR_LAT, 10: cycles from grant to write ready (at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_read  in  NUM_CH  per-channel read request (level).
- mem_write  in  NUM_CH  per-channel write request (level).
- mem_addr  in  NUM_CH*ADDR_W  packed per-channel line addresses; channel i is at slice [i*ADDR_W +: ADDR_W].
- mem_wdata  in  NUM_CH*LINE_W  packed per-channel write lines.
- mem_rdata  out  NUM_CH*LINE_W  packed per-channel read lines.
- mem_ready  out  NUM_CH  one-cycle completion pulse per channel.
- grant  out  NUM_CH  one-hot; marks the channel currently being served.
- busy  out  1  high from grant until completion.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Clock is clk. Reset is synchronous, active-low, on rst_n. Reset is sampled only on the rising edge of clk.
- Reset values:
  - mem_ready = 0, grant = 0, busy = 0, proto_err = 0.
  - mem_rdata = 0.
  - FSM = IDLE; round-robin pointer = channel 0.
  - The line array is NOT reset; benches preload it via hierarchical $readmemb.
- FSM states: IDLE, WAIT, DONE, COOL.
- IDLE:
  - A channel is requesting when mem_read[i] | mem_write[i].
  - When any channel requests, pick the first requester at or after the pointer, wrapping modulo NUM_CH.
  - On that edge, latch channel, op, address and wdata. Set grant and busy. Load the counter with LAT-1. Go to WAIT.
  - If mem_read and mem_write are both high on the granted channel, the op is a write and proto_err is set.
- WAIT:
  - Decrement the counter each cycle. At 0, go to DONE.
  - Inputs are ignored; the latched values are authoritative.
  - A requester dropping its request mid-transaction does not cancel it.
- DONE (one cycle):
  - mem_ready[ch] = 1 for this cycle only.
  - Read: mem_rdata slice ch = array[addr] in this same cycle. The slice holds that value until the next read completes on that channel.
  - Write: the array is updated at the end of this cycle.
  - busy and grant clear on exiting DONE.
  - The pointer advances to ch+1 (mod NUM_CH).
  - Go to COOL.
- COOL (one cycle):
  - Arbitration is suppressed so requesters can deassert.
  - Return to IDLE.
- Latency:
  - Request sampled in IDLE at edge T gives mem_ready high during cycle T+LAT+1.
  - Back-to-back transactions cost LAT+3 cycles.
- Request still asserted in COOL for a channel that just completed: no error. It is re-arbitrated normally in IDLE.
- Read-after-write to the same line from another channel returns the new data, since transactions are serialized.
- Address bits above DEPTH_LOG2 are ignored (aliasing). Nothing is flagged.
- Reset asserted in WAIT or DONE:
  - The transaction is abandoned and no write is committed.
  - No ready pulse is issued.
  - proto_err clears.
- NUM_CH = 1: the arbiter degenerates and grant[0] follows busy.

Decomposition:
- Shared package bsm_pkg:
  - FSM state enum (IDLE/WAIT/DONE/COOL).
  - Op enum (RD/WR).
  - Function clog2 for the channel-index width.
- One natural sub-module: rr_arbiter.
  - Parametrised NUM_CH.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot gnt and binary index.
  - Purely combinational.
- Counter, latches and array stay in the top.

Test Plan:
- Single read: NUM_CH=2, RD_LAT=10, array[5]=0xA5A5…. Ch0 read addr 5 sampled at T -> mem_ready[0] high only at T+11, rdata0=0xA5A5…, busy high T+1..T+11.
- Write then read, same line, different channels: ch1 writes 0x1234 to addr 7, then ch0 reads addr 7 -> ch0 rdata = 0x1234. Total cycles from ch1 grant to ch0 ready = 2*LAT+3.
- Contention: ch0 and ch1 request simultaneously from reset -> ch0 served first, then ch1. With both held continuously, service alternates 0,1,0,1. No channel is granted twice in a row while the other waits.
- Early drop: ch1 read asserted one cycle only -> transaction still completes and mem_ready[1] pulses at grant+LAT.
- Illegal request: ch0 asserts read and write together -> treated as a write, array updated, proto_err=1 and sticky until rst_n=0.
- Reset mid-write: rst_n low during WAIT of a write to addr 3 -> no ready pulse, array[3] unchanged, all outputs 0 on the next edge.
